// File: rtl/name_table_fetcher_pkg.sv
// rtl/name_table_fetcher_pkg.sv - shared name table geometry, packing constants and fetch FSM encoding
package name_table_fetcher_pkg;

    localparam int NT_WIDTH       = 32;
    localparam int NT_HEIGHT      = 30;
    localparam int TILE_PIX       = 8;
    localparam int VISIBLE_LINES  = NT_HEIGHT * TILE_PIX;
    localparam int TILES_PER_WORD = 4;
    localparam int WORDS_PER_ROW  = NT_WIDTH / TILES_PER_WORD;
    localparam int NT_WORDS       = NT_HEIGHT * WORDS_PER_ROW;
    localparam int NT_ADDR_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAP  = 2'd2,
        ST_EMIT = 2'd3
    } nt_state_e;

    // Tile n of a packed word lives in byte n, byte 0 in the low bits
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/name_table_fetcher_scroll_wrap.sv
// rtl/name_table_fetcher_scroll_wrap.sv - line_y + scroll_y modulo visible lines, split into tile row and fine y
module name_table_fetcher_scroll_wrap
    import name_table_fetcher_pkg::*;
(
    input  logic [7:0] line_y,
    input  logic [7:0] scroll_y,
    output logic [4:0] tile_row,
    output logic [2:0] fine_y
);

    logic [8:0] sum;
    logic [8:0] pass1;
    logic [8:0] pass2;
    logic [7:0] eff_y;

    // Sum can reach 494, so at most two subtractions bring it below 240
    always_comb begin
        sum   = {1'b0, line_y} + {1'b0, scroll_y};
        pass1 = (sum   >= 9'(VISIBLE_LINES)) ? sum   - 9'(VISIBLE_LINES) : sum;
        pass2 = (pass1 >= 9'(VISIBLE_LINES)) ? pass1 - 9'(VISIBLE_LINES) : pass1;
        eff_y = 8'(pass2);
    end

    assign tile_row = eff_y[7:3];
    assign fine_y   = eff_y[2:0];

endmodule

// File: rtl/name_table_fetcher.sv
// rtl/name_table_fetcher.sv - per-scanline name table row fetch, unpack and tile index stream
module name_table_fetcher
    import name_table_fetcher_pkg::*;
#(
    parameter int ADDR_W = NT_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              line_start,
    input  logic [7:0]        line_y,
    input  logic [7:0]        scroll_y,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] nt_index,
    input  logic [31:0]       nt_data,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [7:0]        tile_idx,
    output logic [4:0]        tile_col,
    output logic [4:0]        tile_row,
    output logic [2:0]        tile_fine_y,
    output logic              line_done
);

    nt_state_e         state;
    nt_state_e         state_nx;
    logic [ADDR_W-1:0] word_ptr;
    logic [4:0]        col;
    logic [31:0]       word_q;
    logic [4:0]        wrap_row;
    logic [2:0]        wrap_fine;
    logic              accept;
    logic              handshake;
    logic              last_in_word;
    logic              last_in_line;

    name_table_fetcher_scroll_wrap u_scroll_wrap (
        .line_y   (line_y),
        .scroll_y (scroll_y),
        .tile_row (wrap_row),
        .fine_y   (wrap_fine)
    );

    assign accept       = line_start && (state == ST_IDLE) && (line_y < 8'(VISIBLE_LINES));
    assign handshake    = (state == ST_EMIT) && tile_ready;
    assign last_in_word = (col[1:0] == 2'd3);
    assign last_in_line = (col == 5'(NT_WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: one RAM word per REQ/CAP pair, then four tiles out of it
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_REQ;
            ST_REQ:  state_nx = ST_CAP;
            ST_CAP:  state_nx = ST_EMIT;
            ST_EMIT: begin
                if (handshake && last_in_word) begin
                    state_nx = last_in_line ? ST_IDLE : ST_REQ;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Line context, word pointer, column, captured word and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_ptr    <= '0;
            col         <= '0;
            word_q      <= '0;
            tile_row    <= '0;
            tile_fine_y <= '0;
            overrun     <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (line_start && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                word_ptr    <= ADDR_W'({wrap_row, 3'b000});
                col         <= '0;
                tile_row    <= wrap_row;
                tile_fine_y <= wrap_fine;
            end
            if (state == ST_CAP) begin
                word_q <= nt_data;
            end
            if (handshake) begin
                col <= col + 5'd1;
                if (last_in_word && !last_in_line) begin
                    word_ptr <= word_ptr + 1'b1;
                end
                if (last_in_line) begin
                    line_done <= 1'b1;
                end
            end
        end
    end

    // The word pointer is held between lines, so the RAM address stays in range
    assign nt_index   = word_ptr;
    assign busy       = (state != ST_IDLE);
    assign tile_valid = (state == ST_EMIT);
    assign tile_col   = col;
    assign tile_idx   = word_byte(word_q, col[1:0]);

endmodule

// File: tb/tb_name_table_fetcher.sv
// tb/tb_name_table_fetcher.sv - scoreboard bench for name_table_fetcher
module tb_name_table_fetcher;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  line_y = 8'd0;
    logic [7:0]  scroll_y = 8'd0;
    logic        busy;
    logic        overrun;
    logic [7:0]  nt_index;
    logic [31:0] nt_data = 32'd0;
    logic        tile_valid;
    logic        tile_ready = 1'b1;
    logic [7:0]  tile_idx;
    logic [4:0]  tile_col;
    logic [4:0]  tile_row;
    logic [2:0]  tile_fine_y;
    logic        line_done;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int exp_w_lo = 0;
    bit idx_check_en = 1'b0;
    logic [20:0] exp_q[$];

    name_table_fetcher dut (
        .clk         (clk),
        .rstn        (rstn),
        .line_start  (line_start),
        .line_y      (line_y),
        .scroll_y    (scroll_y),
        .busy        (busy),
        .overrun     (overrun),
        .nt_index    (nt_index),
        .nt_data     (nt_data),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_idx    (tile_idx),
        .tile_col    (tile_col),
        .tile_row    (tile_row),
        .tile_fine_y (tile_fine_y),
        .line_done   (line_done)
    );

    always #5 clk = ~clk;

    // Name table RAM model: word k holds tiles 4k..4k+3, one cycle read latency
    always @(posedge clk) begin
        int k;
        k = int'(nt_index);
        nt_data <= {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every presented tile must match the scoreboard head; pop on handshake
    always @(negedge clk) begin
        logic [20:0] e;
        if (tile_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tile: got col %0d idx %0d, none expected", tile_col, tile_idx);
            end else begin
                e = exp_q[0];
                if ({tile_idx, tile_col, tile_row, tile_fine_y} != e) begin
                    fails++;
                    $display("FAIL tile: got idx %0d col %0d row %0d fy %0d expected idx %0d col %0d row %0d fy %0d",
                             tile_idx, tile_col, tile_row, tile_fine_y, e[20:13], e[12:8], e[7:3], e[2:0]);
                end
                if (tile_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end
        if (line_done) done_cnt++;
        if (busy && idx_check_en) begin
            tests++;
            if (int'(nt_index) < exp_w_lo || int'(nt_index) > exp_w_lo + 7) begin
                fails++;
                $display("FAIL nt_index: got %0d expected %0d..%0d", nt_index, exp_w_lo, exp_w_lo + 7);
            end
        end
    end

    task automatic push_line(input int row, input int fy);
        for (int c = 0; c < 32; c++) begin
            exp_q.push_back({8'(row*32 + c), 5'(c), 5'(row), 3'(fy)});
        end
        exp_w_lo = row * 8;
    endtask

    // Run one line; rnd throttles tile_ready, inject_at re-pulses line_start mid-line
    task automatic run_line(input int ly, input int sy, input int row, input int fy,
                            input bit rnd, input bit timing, input int inject_at);
        int cyc;
        int first_valid;
        int hs0;
        int dn0;
        bit seen_done;
        hs0 = hs_cnt;
        dn0 = done_cnt;
        push_line(row, fy);
        idx_check_en = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y = 8'(ly);
        scroll_y = 8'(sy);
        tile_ready = 1'b1;
        cyc = 0;
        first_valid = -1;
        seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            line_start = (cyc == inject_at);
            if (cyc == inject_at) line_y = 8'd5;
            tile_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (tile_valid && first_valid < 0) first_valid = cyc;
            if (line_done) seen_done = 1'b1;
        end
        check("line_done_seen", int'(seen_done), 1);
        if (timing) begin
            check("first_valid_latency", first_valid, 3);
            check("line_done_latency", cyc, 49);
        end
        @(posedge clk); #1;
        line_start = 1'b0;
        tile_ready = 1'b1;
        check("line_done_pulse", int'(line_done), 0);
        check("busy_after_line", int'(busy), 0);
        check("handshakes", hs_cnt - hs0, 32);
        check("queue_drained", exp_q.size(), 0);
        check("line_done_count", done_cnt - dn0, 1);
        idx_check_en = 1'b0;
    endtask

    initial begin
        int dn0;
        int hs0;
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_nt_index", int'(nt_index), 0);
        check("rst_tile_valid", int'(tile_valid), 0);
        check("rst_tile_fields", int'({tile_idx, tile_col, tile_row, tile_fine_y}), 0);
        check("rst_line_done", int'(line_done), 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: unscrolled first line, full throughput
        run_line(0, 0, 0, 0, 1'b0, 1'b1, -1);
        // 2: wrap once: 237+20=257 -> 17
        run_line(237, 20, 2, 1, 1'b0, 1'b1, -1);
        // 3: wrap twice: 239+255=494 -> 14
        run_line(239, 255, 1, 6, 1'b0, 1'b0, -1);

        // 3b: blanking line is ignored
        dn0 = done_cnt;
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y = 8'd240;
        scroll_y = 8'd0;
        @(posedge clk); #1;
        line_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("blank_busy", int'(busy), 0);
            @(posedge clk); #1;
        end
        check("blank_no_done", done_cnt - dn0, 0);
        check("overrun_clear", int'(overrun), 0);

        // 4: random backpressure
        run_line(100, 3, 12, 7, 1'b1, 1'b0, -1);
        // 5: second start mid-line is dropped and flagged
        run_line(8, 0, 1, 0, 1'b0, 1'b0, 10);
        check("overrun_set", int'(overrun), 1);
        run_line(16, 0, 2, 0, 1'b1, 1'b0, -1);
        check("overrun_sticky", int'(overrun), 1);

        // 6: reset while column 13 is presented
        hs0 = hs_cnt;
        dn0 = done_cnt;
        push_line(3, 0);
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y = 8'd24;
        @(posedge clk); #1;
        line_start = 1'b0;
        guard = 0;
        while (hs_cnt - hs0 < 13 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_col13", hs_cnt - hs0, 13);
        check("col13_presented", int'(tile_col), 13);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(tile_valid), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_nt_index", int'(nt_index), 0);
        check("mid_rst_fields", int'({tile_idx, tile_col, tile_row, tile_fine_y}), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - dn0, 0);
        run_line(50, 0, 6, 2, 1'b0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
